// File: rtl/lane_deinterleave_rx_if.sv
// lane_deinterleave_rx_if
// Purpose : groups the two handshakes of the lane de-interleaver.
//           The beat side carries tagged, interleaved lane beats.
//           The pair side carries each rebuilt A/B lane pair.
// Signals : i_valid/i_sel/i_data/o_ready -- beat stream (i_sel: 1 = lane A, 0 = lane B)
//           o_valid/i_ready/o_a/o_b      -- reconstructed pair stream
// Modports: master -- the environment (drives beats, accepts pairs)
//           slave  -- the receiver
interface lane_deinterleave_rx_if #(
   parameter int DATA_W = 2
);
   logic              i_valid;
   logic              i_sel;
   logic [DATA_W-1:0] i_data;
   logic              o_ready;
   logic              o_valid;
   logic              i_ready;
   logic [DATA_W-1:0] o_a;
   logic [DATA_W-1:0] o_b;

   modport master (
      output i_valid, i_sel, i_data, i_ready,
      input  o_ready, o_valid, o_a, o_b
   );

   modport slave (
      input  i_valid, i_sel, i_data, i_ready,
      output o_ready, o_valid, o_a, o_b
   );
endinterface

// File: rtl/lane_deinterleave_rx.sv
// lane_deinterleave_rx
// Purpose : receive side of the two-lane time-multiplexed link. Rebuilds
//           A/B lane pairs from the tagged beat stream. Presents each pair over
//           valid/ready. Counts lane-ordering errors and resynchronises
//           without stalling.
// Ports   : i_clk       -- clock, rising edge
//           i_rst       -- asynchronous reset, active low
//           bus         -- beat and pair handshakes (slave modport)
//           o_err_pulse -- one-cycle pulse per ordering error
//           o_err_cnt   -- saturating ordering-error count
//
// state  | meaning
// -------+-------------------------------------------------------------
// WAIT_A | expecting a lane A beat; a B beat here is dropped as an error
// WAIT_B | A captured, expecting lane B; a repeated A replaces the old A
// FULL   | pair held on o_a/o_b with o_valid high until downstream pops
module lane_deinterleave_rx #(
   parameter int DATA_W    = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   lane_deinterleave_rx_if.slave bus,
   output logic                 o_err_pulse,
   output logic [ERR_CNT_W-1:0] o_err_cnt
);

   typedef enum logic [1:0] {
      WAIT_A = 2'd0,
      WAIT_B = 2'd1,
      FULL   = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_valid;
   logic [DATA_W-1:0]    r_a;
   logic [DATA_W-1:0]    r_b;
   logic                 r_err_pulse;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   logic                 w_ready;
   logic                 w_xfer;
   logic                 w_err;

   // In FULL a beat is only taken when the held pair pops in the same
   // cycle. This keeps the link at full rate without a holding buffer.
   // Reset gates ready so that no beat is taken while i_rst is low.
   assign w_ready = i_rst & ((r_state != FULL) | bus.i_ready);
   assign w_xfer  = bus.i_valid & w_ready;

   always_comb begin
      w_err = 1'b0;
      if (w_xfer) begin
         case (r_state)
            WAIT_A:  w_err = ~bus.i_sel;
            WAIT_B:  w_err = bus.i_sel;
            FULL:    w_err = ~bus.i_sel;
            default: w_err = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= WAIT_A;
         r_valid     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_err_pulse <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_err_pulse <= w_err;
         if (w_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end

         case (r_state)
            WAIT_A: begin
               if (w_xfer && bus.i_sel) begin
                  r_a     <= bus.i_data;
                  r_state <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (w_xfer) begin
                  if (bus.i_sel) begin
                     r_a <= bus.i_data;
                  end else begin
                     r_b     <= bus.i_data;
                     r_valid <= 1'b1;
                     r_state <= FULL;
                  end
               end
            end
            FULL: begin
               if (bus.i_ready) begin
                  r_valid <= 1'b0;
                  if (w_xfer && bus.i_sel) begin
                     r_a     <= bus.i_data;
                     r_state <= WAIT_B;
                  end else begin
                     r_state <= WAIT_A;
                  end
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= WAIT_A;
            end
         endcase
      end
   end

   assign bus.o_ready = w_ready;
   assign bus.o_valid = r_valid;
   assign bus.o_a     = r_a;
   assign bus.o_b     = r_b;
   assign o_err_pulse = r_err_pulse;
   assign o_err_cnt   = r_err_cnt;

endmodule
